fifo_1r1w_flags: RTL and testbench



---
 rtl/fifo_pkg.sv | 20 ++
 rtl/fifo_wrap_ptr.sv | 38 +++
 rtl/fifo_1r1w_flags.sv | 110 +++++++++++
 tb/tb_fifo_1r1w_flags.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared sizing helpers and parameter legality check for the 1R1W FIFO family.
package fifo_pkg;

  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int unsigned count_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Evaluated at elaboration; the top raises an error when this is false.
  function automatic bit params_legal(input int unsigned width,
                                      input int unsigned depth,
                                      input int unsigned af_margin,
                                      input int unsigned ae_margin);
    return (width >= 1) && (depth >= 2) && (af_margin < depth) && (ae_margin < depth);
  endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Modulo-depth pointer: counts 0..depth_p-1 and wraps, with synchronous clear.
module fifo_wrap_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned depth_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_n_i,
  input  logic                          clear_i,
  input  logic                          inc_i,
  output logic [ptr_width(depth_p)-1:0] ptr_o
);

  localparam int unsigned ptr_w_lp = ptr_width(depth_p);
  localparam logic [ptr_w_lp-1:0] last_idx_lp = ptr_w_lp'(depth_p - 1);

  logic [ptr_w_lp-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clear_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = (ptr_q == last_idx_lp) ? '0 : ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_1r1w_flags.sv
// Single-read/single-write FIFO with occupancy count, threshold flags, flush and
// sticky underflow. Input valid/ready, output valid/yumi, first-word fall-through.
module fifo_1r1w_flags
  import fifo_pkg::*;
#(
  parameter int unsigned width_p     = 8,
  parameter int unsigned depth_p     = 16,
  parameter int unsigned af_margin_p = 2,
  parameter int unsigned ae_margin_p = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic                            clear_i,
  input  logic [width_p-1:0]              data_i,
  input  logic                            valid_i,
  output logic                            ready_o,
  output logic                            valid_o,
  output logic [width_p-1:0]              data_o,
  input  logic                            yumi_i,
  output logic [count_width(depth_p)-1:0] count_o,
  output logic                            almost_full_o,
  output logic                            almost_empty_o,
  output logic                            underflow_o
);

  localparam int unsigned ptr_w_lp = ptr_width(depth_p);
  localparam int unsigned cnt_w_lp = count_width(depth_p);

  localparam logic [cnt_w_lp-1:0] depth_lp     = cnt_w_lp'(depth_p);
  localparam logic [cnt_w_lp-1:0] af_thresh_lp = cnt_w_lp'(depth_p - af_margin_p);
  localparam logic [cnt_w_lp-1:0] ae_thresh_lp = cnt_w_lp'(ae_margin_p);

  if (!params_legal(width_p, depth_p, af_margin_p, ae_margin_p)) begin : g_bad_params
    $error("fifo_1r1w_flags: illegal width_p/depth_p/af_margin_p/ae_margin_p");
  end

  logic [width_p-1:0]  mem_q [depth_p];
  logic [ptr_w_lp-1:0] wr_ptr, rd_ptr;
  logic [cnt_w_lp-1:0] count_d, count_q;
  logic                underflow_d, underflow_q;
  logic                enq, deq;

  assign ready_o = (count_q != depth_lp) & reset_n_i;
  assign valid_o = (count_q != '0);
  assign enq     = valid_i & ready_o;
  assign deq     = yumi_i & valid_o;

  fifo_wrap_ptr #(
    .depth_p (depth_p)
  ) u_wr_ptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .inc_i     (enq),
    .ptr_o     (wr_ptr)
  );

  fifo_wrap_ptr #(
    .depth_p (depth_p)
  ) u_rd_ptr (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .clear_i   (clear_i),
    .inc_i     (deq),
    .ptr_o     (rd_ptr)
  );

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk_i) begin
    if (enq && !clear_i) begin
      mem_q[wr_ptr] <= data_i;
    end
  end

  assign data_o = mem_q[rd_ptr];

  always_comb begin
    count_d     = count_q;
    underflow_d = underflow_q;
    if (clear_i) begin
      count_d     = '0;
      underflow_d = 1'b0;
    end else begin
      if (enq && !deq) begin
        count_d = count_q + 1'b1;
      end else if (deq && !enq) begin
        count_d = count_q - 1'b1;
      end
      if (yumi_i && !valid_o) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  assign count_o        = count_q;
  assign underflow_o    = underflow_q;
  assign almost_full_o  = (count_q >= af_thresh_lp);
  assign almost_empty_o = (count_q <= ae_thresh_lp);

endmodule

// File: tb/tb_fifo_1r1w_flags.sv
// Bench for fifo_1r1w_flags: directed scenarios on a depth-5 instance plus randomized
// traffic against queue models on depth 5/2/16 and widths 8/1/32.
module tb_fifo_1r1w_flags;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clear, valid, yumi;
  logic [31:0] din;

  // Main instance: width 8, depth 5, af 1, ae 1
  logic       ready, valid_o, af, ae, uf;
  logic [7:0] dout;
  logic [2:0] count;
  // Sweep instance A: width 1, depth 2, af 0, ae 1
  logic       s0_ready, s0_valid, s0_af, s0_ae, s0_uf, s0_data;
  logic [1:0] s0_count;
  // Sweep instance B: width 32, depth 16, af 2, ae 2
  logic        s1_ready, s1_valid, s1_af, s1_ae, s1_uf;
  logic [31:0] s1_data;
  logic [4:0]  s1_count;

  fifo_1r1w_flags #(.width_p(8), .depth_p(5), .af_margin_p(1), .ae_margin_p(1)) dut (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .data_i(din[7:0]), .valid_i(valid),
    .ready_o(ready), .valid_o(valid_o), .data_o(dout), .yumi_i(yumi), .count_o(count),
    .almost_full_o(af), .almost_empty_o(ae), .underflow_o(uf)
  );

  fifo_1r1w_flags #(.width_p(1), .depth_p(2), .af_margin_p(0), .ae_margin_p(1)) dut_s0 (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .data_i(din[0]), .valid_i(valid),
    .ready_o(s0_ready), .valid_o(s0_valid), .data_o(s0_data), .yumi_i(yumi),
    .count_o(s0_count), .almost_full_o(s0_af), .almost_empty_o(s0_ae), .underflow_o(s0_uf)
  );

  fifo_1r1w_flags #(.width_p(32), .depth_p(16), .af_margin_p(2), .ae_margin_p(2)) dut_s1 (
    .clk_i(clk), .reset_n_i(reset_n), .clear_i(clear), .data_i(din), .valid_i(valid),
    .ready_o(s1_ready), .valid_o(s1_valid), .data_o(s1_data), .yumi_i(yumi),
    .count_o(s1_count), .almost_full_o(s1_af), .almost_empty_o(s1_ae), .underflow_o(s1_uf)
  );

  logic [31:0] a_cnt [3];
  logic [31:0] a_data[3];
  logic [4:0]  a_flags[3];  // {valid, ready, af, ae, uf}
  assign a_cnt[0]   = 32'(count);
  assign a_cnt[1]   = 32'(s0_count);
  assign a_cnt[2]   = 32'(s1_count);
  assign a_data[0]  = 32'(dout);
  assign a_data[1]  = 32'(s0_data);
  assign a_data[2]  = s1_data;
  assign a_flags[0] = {valid_o, ready, af, ae, uf};
  assign a_flags[1] = {s0_valid, s0_ready, s0_af, s0_ae, s0_uf};
  assign a_flags[2] = {s1_valid, s1_ready, s1_af, s1_ae, s1_uf};

  int          n_checks = 0;
  int          n_errors = 0;
  int          dep[3] = '{5, 2, 16};
  int          afm[3] = '{1, 0, 2};
  int          aem[3] = '{1, 1, 2};
  logic [31:0] msk[3] = '{32'hFF, 32'h1, 32'hFFFF_FFFF};
  logic [31:0] mq[3][$];
  bit          m_uf[3];

  function automatic logic [4:0] exp_flags(input int i);
    int n;
    n = mq[i].size();
    return {n != 0, (n != dep[i]) && reset_n, n >= dep[i] - afm[i], n <= aem[i], m_uf[i]};
  endfunction

  // Advance every reference model by the inputs present at this edge, then step the clock.
  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      int n;
      bit e, d;
      n = mq[i].size();
      if (!reset_n || clear) begin
        mq[i].delete();
        m_uf[i] = 1'b0;
      end else begin
        e = valid && (n != dep[i]);
        d = yumi && (n != 0);
        if (yumi && n == 0) m_uf[i] = 1'b1;
        if (d) void'(mq[i].pop_front());
        if (e) mq[i].push_back(din & msk[i]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; clear = 1'b0; valid = 1'b0; yumi = 1'b0; din = '0;
    repeat (2) tick();
    reset_n = 1'b1;
    valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      din = 32'(k);
      tick();
    end
    valid = 1'b0;
    n_checks++;
    if (count !== 3'd3) begin
      n_errors++; $display("FAIL pre_reset_count got %0d want 3", count);
    end
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({count, valid_o, ready, ae, af, uf} !== {3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      n_errors++;
      $display("FAIL async_reset got cnt=%0d v=%0b r=%0b ae=%0b af=%0b uf=%0b want 0 0 0 1 0 0",
               count, valid_o, ready, ae, af, uf);
    end
    tick();
    reset_n = 1'b1;
    valid = 1'b1;
    din = 32'hA5;
    tick();
    valid = 1'b0;
    n_checks++;
    if (valid_o !== 1'b1 || dout !== 8'hA5 || count !== 3'd1) begin
      n_errors++;
      $display("FAIL first_write got v=%0b d=%h cnt=%0d want 1 a5 1", valid_o, dout, count);
    end
  endtask

  task automatic test_fill_drain();
    clear = 1'b1; tick(); clear = 1'b0;
    valid = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      din = 32'(k);
      tick();
      n_checks++;
      if (count !== 3'(k) || af !== (k >= 4)) begin
        n_errors++; $display("FAIL fill got cnt=%0d af=%0b want %0d %0b", count, af, k, k >= 4);
      end
    end
    din = 32'h06;
    n_checks++;
    if (ready !== 1'b0) begin
      n_errors++; $display("FAIL full_ready got %0b want 0", ready);
    end
    tick();
    valid = 1'b0;
    n_checks++;
    if (count !== 3'd5) begin
      n_errors++; $display("FAIL write_when_full got cnt=%0d want 5", count);
    end
    yumi = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (dout !== 8'(k)) begin
        n_errors++; $display("FAIL drain_order got %h want %h", dout, 8'(k));
      end
      tick();
      n_checks++;
      if (count !== 3'(5 - k) || ae !== (5 - k <= 1)) begin
        n_errors++;
        $display("FAIL drain got cnt=%0d ae=%0b want %0d %0b", count, ae, 5 - k, 5 - k <= 1);
      end
    end
    yumi = 1'b0;
    n_checks++;
    if (valid_o !== 1'b0) begin
      n_errors++; $display("FAIL drained_valid got %0b want 0", valid_o);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] expq[$];
    clear = 1'b1; tick(); clear = 1'b0;
    valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      din = 32'(8'h0E + k);
      expq.push_back(8'(8'h0E + k));
      tick();
    end
    yumi = 1'b1;
    for (int k = 0; k < 12; k++) begin
      din = 32'(8'h10 + k);
      n_checks++;
      if (dout !== expq[0]) begin
        n_errors++; $display("FAIL wrap_order got %h want %h", dout, expq[0]);
      end
      void'(expq.pop_front());
      expq.push_back(8'(8'h10 + k));
      tick();
      n_checks++;
      if (count !== 3'd2) begin
        n_errors++; $display("FAIL wrap_count got %0d want 2", count);
      end
    end
    valid = 1'b0;
    yumi = 1'b0;
  endtask

  task automatic test_full_yumi();
    clear = 1'b1; tick(); clear = 1'b0;
    valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      din = 32'(8'h21 + k);
      tick();
    end
    din = 32'h77;
    yumi = 1'b1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_errors++; $display("FAIL full_yumi_ready got %0b want 0", ready);
    end
    tick();
    yumi = 1'b0;
    n_checks++;
    if (count !== 3'd4 || dout !== 8'h22) begin
      n_errors++; $display("FAIL full_yumi_deq got cnt=%0d d=%h want 4 22", count, dout);
    end
    tick();
    valid = 1'b0;
    n_checks++;
    if (count !== 3'd5) begin
      n_errors++; $display("FAIL full_yumi_enq got cnt=%0d want 5", count);
    end
    yumi = 1'b1;
    repeat (4) tick();
    yumi = 1'b0;
    n_checks++;
    if (count !== 3'd1 || dout !== 8'h77) begin
      n_errors++; $display("FAIL full_yumi_tail got cnt=%0d d=%h want 1 77", count, dout);
    end
  endtask

  task automatic test_underflow();
    clear = 1'b1; tick(); clear = 1'b0;
    yumi = 1'b1;
    tick();
    yumi = 1'b0;
    tick();
    n_checks++;
    if (count !== 3'd0 || uf !== 1'b1) begin
      n_errors++; $display("FAIL underflow got cnt=%0d uf=%0b want 0 1", count, uf);
    end
    clear = 1'b1; valid = 1'b1; din = 32'h33;
    tick();
    clear = 1'b0; valid = 1'b0;
    n_checks++;
    if (count !== 3'd0 || uf !== 1'b0 || valid_o !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_prio got cnt=%0d uf=%0b v=%0b want 0 0 0", count, uf, valid_o);
    end
  endtask

  task automatic test_random();
    clear = 1'b1; tick(); clear = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      valid = ($urandom_range(99) < 55);
      yumi  = ($urandom_range(99) < 45);
      clear = ($urandom_range(63) == 0);
      din   = $urandom;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (a_flags[i] !== exp_flags(i) || a_cnt[i] !== 32'(mq[i].size())) begin
          n_errors++;
          $display("FAIL random inst%0d got flags=%b cnt=%0d want %b %0d", i, a_flags[i],
                   a_cnt[i], exp_flags(i), mq[i].size());
        end
        if (mq[i].size() != 0) begin
          n_checks++;
          if (a_data[i] !== mq[i][0]) begin
            n_errors++; $display("FAIL random_data inst%0d got %h want %h", i, a_data[i], mq[i][0]);
          end
        end
      end
      tick();
    end
    clear = 1'b0; valid = 1'b0; yumi = 1'b0;
  endtask

  // Fill, drain, then steady enq+deq on every instance, checked against its model.
  task automatic test_sweep();
    for (int cyc = 0; cyc < 52; cyc++) begin
      clear = (cyc == 0);
      valid = (cyc >= 1 && cyc < 18) || (cyc >= 36);
      yumi  = (cyc >= 18 && cyc < 35) || (cyc >= 38);
      din   = $urandom;
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (a_flags[i] !== exp_flags(i) || a_cnt[i] !== 32'(mq[i].size())) begin
          n_errors++;
          $display("FAIL sweep inst%0d cyc%0d got flags=%b cnt=%0d want %b %0d", i, cyc,
                   a_flags[i], a_cnt[i], exp_flags(i), mq[i].size());
        end
        if (mq[i].size() != 0) begin
          n_checks++;
          if (a_data[i] !== mq[i][0]) begin
            n_errors++; $display("FAIL sweep_data inst%0d got %h want %h", i, a_data[i], mq[i][0]);
          end
        end
      end
      tick();
    end
    clear = 1'b0; valid = 1'b0; yumi = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_full_yumi();
    test_underflow();
    test_random();
    test_sweep();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
